// File: rtl/pipe_skid_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_skid_stage_pkg
// Purpose : Shared types and defaults for the two-entry skid pipeline stage.
//           Holds the parameter defaults, the packed control word that travels
//           with each payload, and the bubble control word that is driven
//           whenever the stage has nothing to present.
// Revision: 1.0  initial release
// ============================================================================
package pipe_skid_stage_pkg;

    localparam int ELEM_SIZE_DEF = 8;
    localparam int VECT_SIZE_DEF = 8;
    localparam int REGI_BITS_DEF = 4;
    localparam int VECT_BITS_DEF = 2;
    localparam int ADDR_BITS_DEF = 10;
    localparam int CNT_W_DEF     = 16;

    // The end-of-program flag is called end_prog because "end" is a keyword.
    typedef struct packed {
        logic                     enable_reg;
        logic                     enable_jump;
        logic                     mem_read;
        logic                     mem_write;
        logic                     end_prog;
        logic                     nop;
        logic                     write_result_int;
        logic                     write_result_v;
        logic [ADDR_BITS_DEF-1:0] jump_address;
        logic [REGI_BITS_DEF-1:0] int_reg_dest;
        logic [VECT_BITS_DEF-1:0] vec_reg_dest;
    } stage_ctrl_t;

    // Empty slot: everything zero except nop.
    localparam stage_ctrl_t BUBBLE_CTRL = '{
        enable_reg:       1'b0,
        enable_jump:      1'b0,
        mem_read:         1'b0,
        mem_write:        1'b0,
        end_prog:         1'b0,
        nop:              1'b1,
        write_result_int: 1'b0,
        write_result_v:   1'b0,
        jump_address:     '0,
        int_reg_dest:     '0,
        vec_reg_dest:     '0
    };

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : sat_counter
// Purpose : Up-counter that sticks at its all-ones value. A clear request wins
//           over an increment in the same cycle.
// Ports   : clk   - clock, rising edge
//           rst   - asynchronous active-high reset, count -> 0
//           inc   - count up by one this cycle (unless saturated)
//           clr   - synchronous clear, priority over inc
//           count - current value
// Revision: 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module  : pipe_skid_stage
// Purpose : Two-entry valid/ready pipeline stage. MAIN drives the outputs,
//           SKID catches an entry arriving while MAIN is stalled, so ready_o
//           depends only on registered state. Supports a synchronous flush,
//           an end-of-program halt and a saturating back-pressure counter.
// Ports   : clk_i, rst_i            - clock / async active-high reset
//           flush_i                 - drop all held entries, clear halt
//           valid_i, ready_o        - upstream handshake
//           data_i, ctrl_i          - upstream payload and control
//           valid_o, ready_i        - downstream handshake
//           data_o, ctrl_o          - head payload/control (zero/bubble if empty)
//           occ_o                   - number of held entries, 0..2
//           halted_o                - an end-of-program entry was accepted
//           stall_cnt_clr_i         - clear the back-pressure counter
//           stall_cnt_o             - cycles with valid_o && !ready_i
// Revision: 1.0  initial release
// ============================================================================
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int ELEM_SIZE = ELEM_SIZE_DEF,
    parameter int VECT_SIZE = VECT_SIZE_DEF,
    parameter int REGI_BITS = REGI_BITS_DEF,
    parameter int VECT_BITS = VECT_BITS_DEF,
    parameter int ADDR_BITS = ADDR_BITS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           flush_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [ELEM_SIZE*VECT_SIZE-1:0] data_i,
    input  stage_ctrl_t                    ctrl_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [ELEM_SIZE*VECT_SIZE-1:0] data_o,
    output stage_ctrl_t                    ctrl_o,
    output logic [1:0]                     occ_o,
    output logic                           halted_o,
    input  logic                           stall_cnt_clr_i,
    output logic [CNT_W-1:0]               stall_cnt_o
);

    localparam int DATA_W = ELEM_SIZE * VECT_SIZE;

    // The control word layout is fixed by the package, so the index widths
    // given here must agree with it.
    generate
        if ((REGI_BITS != REGI_BITS_DEF) || (VECT_BITS != VECT_BITS_DEF) ||
            (ADDR_BITS != ADDR_BITS_DEF)) begin : g_ctrl_width_check
            $error("pipe_skid_stage: index widths must match stage_ctrl_t");
        end
    endgenerate

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    stage_ctrl_t       r_main_ctrl;
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    stage_ctrl_t       r_skid_ctrl;
    logic              r_halted;

    logic              w_in_xfer;
    logic              w_out_xfer;

    // Registered terms only (plus reset), never valid_i or ready_i.
    assign ready_o    = !r_skid_valid && !r_halted && !rst_i;
    assign w_in_xfer  = valid_i && ready_o;
    assign w_out_xfer = r_main_valid && ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= BUBBLE_CTRL;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= BUBBLE_CTRL;
            r_halted     <= 1'b0;
        end else if (flush_i) begin
            // A delivery this cycle still happened; an arrival is discarded.
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            if (w_in_xfer && ctrl_i.end_prog) begin
                r_halted <= 1'b1;
            end
            if (!r_main_valid || w_out_xfer) begin
                // MAIN is free at this edge: the older SKID entry goes first,
                // otherwise the arriving entry (if any) goes straight in.
                if (r_skid_valid) begin
                    r_main_valid <= 1'b1;
                    r_main_data  <= r_skid_data;
                    r_main_ctrl  <= r_skid_ctrl;
                    r_skid_valid <= 1'b0;
                end else begin
                    r_main_valid <= w_in_xfer;
                    if (w_in_xfer) begin
                        r_main_data <= data_i;
                        r_main_ctrl <= ctrl_i;
                    end
                end
            end else if (w_in_xfer) begin
                // MAIN stalled and SKID empty (ready_o guarantees it).
                r_skid_valid <= 1'b1;
                r_skid_data  <= data_i;
                r_skid_ctrl  <= ctrl_i;
            end
        end
    end

    assign valid_o  = r_main_valid;
    assign data_o   = r_main_valid ? r_main_data : '0;
    assign ctrl_o   = r_main_valid ? r_main_ctrl : BUBBLE_CTRL;
    assign occ_o    = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
    assign halted_o = r_halted;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .inc   (r_main_valid && !ready_i),
        .clr   (stall_cnt_clr_i),
        .count (stall_cnt_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipe_skid_stage
// Purpose : Scoreboard bench for pipe_skid_stage. Directed stimulus pushes the
//           expected head entries into a queue; a negedge monitor pops and
//           compares on every output transfer. A second instance with a
//           3-bit stall counter shares the same stimulus.
// Revision: 1.0  initial release
// ============================================================================
module tb_pipe_skid_stage;
    import pipe_skid_stage_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        stall_cnt_clr_i = 1'b0;
    logic [63:0] data_i = '0;
    stage_ctrl_t ctrl_i = '0;

    logic        ready_o, valid_o, halted_o;
    logic [63:0] data_o;
    stage_ctrl_t ctrl_o;
    logic [1:0]  occ_o;
    logic [15:0] stall_cnt_o;

    logic        ready_o3, valid_o3, halted_o3;
    logic [63:0] data_o3;
    stage_ctrl_t ctrl_o3;
    logic [1:0]  occ_o3;
    logic [2:0]  stall_cnt_o3;

    pipe_skid_stage u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .ctrl_i(ctrl_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .ctrl_o(ctrl_o),
        .occ_o(occ_o), .halted_o(halted_o),
        .stall_cnt_clr_i(stall_cnt_clr_i), .stall_cnt_o(stall_cnt_o)
    );

    pipe_skid_stage #(.CNT_W(3)) u_dut3 (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o3), .data_i(data_i), .ctrl_i(ctrl_i),
        .valid_o(valid_o3), .ready_i(ready_i), .data_o(data_o3), .ctrl_o(ctrl_o3),
        .occ_o(occ_o3), .halted_o(halted_o3),
        .stall_cnt_clr_i(stall_cnt_clr_i), .stall_cnt_o(stall_cnt_o3)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [63:0] data;
        stage_ctrl_t ctrl;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic stage_ctrl_t mk_ctrl(input int k, input bit is_end);
        stage_ctrl_t c;
        c                  = '0;
        c.enable_reg       = k[0];
        c.mem_read         = k[1];
        c.write_result_int = k[2];
        c.jump_address     = 10'(k * 37 + 1);
        c.int_reg_dest     = 4'(k);
        c.vec_reg_dest     = 2'(k + 1);
        c.end_prog         = is_end;
        return c;
    endfunction

    // Drive one entry for the coming edge; queue it when it must be accepted.
    task automatic push(input logic [63:0] d, input stage_ctrl_t c, input bit accepted);
        valid_i = 1'b1;
        data_i  = d;
        ctrl_i  = c;
        if (accepted) exp_q.push_back('{data: d, ctrl: c});
    endtask

    // Monitor: every output transfer must match the queue head; an empty
    // stage must present zero data and the bubble control word.
    always @(negedge clk_i) begin
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL out_unexpected: got data %0h, expected no transfer", data_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", data_o, mon_e.data);
                check("out_ctrl", 64'(ctrl_o), 64'(mon_e.ctrl));
            end
        end else if (!valid_o) begin
            check("bubble_data", data_o, 64'h0);
            check("bubble_ctrl", 64'(ctrl_o), 64'(BUBBLE_CTRL));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_occ", 64'(occ_o), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_halted", 64'(halted_o), 64'd0);
        check("rst_stall", 64'(stall_cnt_o), 64'd0);
        check("rst_ctrl", 64'(ctrl_o), 64'(BUBBLE_CTRL));
        rst_i = 1'b0;
        #1;
        check("post_rst_ready", 64'(ready_o), 64'd1);

        // Single entry straight through
        ready_i = 1'b1;
        push(64'h0102030405060708, mk_ctrl(1, 1'b0), 1'b1);
        step();
        valid_i = 1'b0;
        check("single_valid", 64'(valid_o), 64'd1);
        check("single_occ1", 64'(occ_o), 64'd1);
        step();
        check("single_valid_gone", 64'(valid_o), 64'd0);
        check("single_occ0", 64'(occ_o), 64'd0);

        // Fill both entries, third refused, then drain in order
        ready_i = 1'b0;
        push(64'hAAAA_0000_0000_000A, mk_ctrl(2, 1'b0), 1'b1);
        step();
        push(64'hBBBB_0000_0000_000B, mk_ctrl(3, 1'b0), 1'b1);
        step();
        check("full_occ", 64'(occ_o), 64'd2);
        check("full_ready", 64'(ready_o), 64'd0);
        push(64'hCCCC_0000_0000_000C, mk_ctrl(4, 1'b0), 1'b0);
        step();
        valid_i = 1'b0;
        check("full_refuse_occ", 64'(occ_o), 64'd2);
        ready_i = 1'b1;
        step();
        check("drain_occ1", 64'(occ_o), 64'd1);
        step();
        check("drain_occ0", 64'(occ_o), 64'd0);

        // Stall counter, including saturation on the 3-bit instance
        ready_i = 1'b0;
        push(64'hDDDD_0000_0000_000D, mk_ctrl(5, 1'b0), 1'b1);
        step();
        valid_i = 1'b0;
        stall_cnt_clr_i = 1'b1;
        step();
        stall_cnt_clr_i = 1'b0;
        check("stall_clr_start", 64'(stall_cnt_o), 64'd0);
        repeat (5) step();
        check("stall_5", 64'(stall_cnt_o), 64'd5);
        repeat (5) step();
        check("stall_10", 64'(stall_cnt_o), 64'd10);
        check("stall_sat3", 64'(stall_cnt_o3), 64'd7);
        stall_cnt_clr_i = 1'b1;
        step();
        stall_cnt_clr_i = 1'b0;
        check("stall_clr", 64'(stall_cnt_o), 64'd0);
        check("stall_clr3", 64'(stall_cnt_o3), 64'd0);
        ready_i = 1'b1;
        step();
        check("stall_drain_occ", 64'(occ_o), 64'd0);

        // Flush with both entries held and an entry offered
        ready_i = 1'b0;
        push(64'hEEEE_0000_0000_000E, mk_ctrl(6, 1'b0), 1'b1);
        step();
        push(64'hFFFF_0000_0000_000F, mk_ctrl(7, 1'b0), 1'b1);
        step();
        check("pre_flush_occ", 64'(occ_o), 64'd2);
        flush_i = 1'b1;
        push(64'h1111_0000_0000_0001, mk_ctrl(8, 1'b0), 1'b0);
        step();
        exp_q.delete();
        check("flush_occ", 64'(occ_o), 64'd0);
        check("flush_valid", 64'(valid_o), 64'd0);
        check("flush_nop", 64'(ctrl_o.nop), 64'd1);
        // Flush into an empty, ready stage: the accepted-looking entry is dropped
        check("flush_ready", 64'(ready_o), 64'd1);
        push(64'h2222_0000_0000_0002, mk_ctrl(9, 1'b0), 1'b0);
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("flush_drop_occ", 64'(occ_o), 64'd0);
        step();
        check("flush_drop_occ2", 64'(occ_o), 64'd0);

        // End-of-program entry halts intake, is still delivered, flush resumes
        push(64'h3333_0000_0000_0003, mk_ctrl(10, 1'b1), 1'b1);
        step();
        valid_i = 1'b0;
        check("halt_set", 64'(halted_o), 64'd1);
        check("halt_ready", 64'(ready_o), 64'd0);
        check("halt_valid", 64'(valid_o), 64'd1);
        ready_i = 1'b1;
        step();
        check("halt_drain_occ", 64'(occ_o), 64'd0);
        check("halt_kept", 64'(halted_o), 64'd1);
        ready_i = 1'b0;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("halt_clear", 64'(halted_o), 64'd0);
        check("halt_ready_back", 64'(ready_o), 64'd1);

        // Asynchronous reset between edges with both entries held
        push(64'h4444_0000_0000_0004, mk_ctrl(11, 1'b0), 1'b1);
        step();
        push(64'h5555_0000_0000_0005, mk_ctrl(12, 1'b0), 1'b1);
        step();
        valid_i = 1'b0;
        check("pre_rst_occ", 64'(occ_o), 64'd2);
        #2;
        rst_i = 1'b1;
        #1;
        exp_q.delete();
        check("arst_occ", 64'(occ_o), 64'd0);
        check("arst_valid", 64'(valid_o), 64'd0);
        check("arst_data", data_o, 64'h0);
        check("arst_ctrl", 64'(ctrl_o), 64'(BUBBLE_CTRL));
        check("arst_ready", 64'(ready_o), 64'd0);
        check("arst_stall", 64'(stall_cnt_o), 64'd0);
        step();
        rst_i = 1'b0;
        step();
        check("arst_release_ready", 64'(ready_o), 64'd1);
        check("arst_release_occ", 64'(occ_o), 64'd0);
        ready_i = 1'b1;
        push(64'h6666_0000_0000_0006, mk_ctrl(13, 1'b0), 1'b1);
        step();
        valid_i = 1'b0;
        step();
        check("final_occ", 64'(occ_o), 64'd0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter ELEM_SIZE, 8, bits per vector element.
REQ-002 Parameter VECT_SIZE, 8, elements per payload; DATA_W = ELEM_SIZE*VECT_SIZE.
REQ-003 Parameter REGI_BITS, 4, integer destination-register index width.
REQ-004 Parameter VECT_BITS, 2, vector destination-register index width.
REQ-005 Parameter ADDR_BITS, 10, jump-address width.
REQ-006 Parameter CNT_W, 16, stall-counter width.
REQ-007 Clock and reset: one clock, clk_i; reset rst_i is asynchronous and active-high.
REQ-008 clk_i  in  1  clock, all state updates on rising edge.
REQ-009 rst_i  in  1  asynchronous active-high reset.
REQ-010 flush_i  in  1  synchronous pipeline flush.
REQ-011 valid_i  in  1  upstream entry valid.
REQ-012 ready_o  out  1  stage accepts an entry this cycle.
REQ-013 data_i  in  DATA_W  payload (result/read data).
REQ-014 ctrl_i  in  stage_ctrl_t  enableReg, enableJump, memRead, memWrite, end, nop, writeResultInt, writeResultV, jumpAddress, intRegDest, vecRegDest.
REQ-015 valid_o  out  1  downstream entry valid.
REQ-016 ready_i  in  1  downstream accepts.
REQ-017 data_o  out  DATA_W  head payload.
REQ-018 ctrl_o  out  stage_ctrl_t  head control.
REQ-019 occ_o  out  2  entries held (0..2).
REQ-020 halted_o  out  1  end-of-program entry accepted.
REQ-021 stall_cnt_clr_i  in  1  synchronous stall-counter clear.
REQ-022 stall_cnt_o  out  CNT_W  back-pressure cycle count.

Function
REQ-023 Two entries, MAIN (drives outputs) and SKID; FIFO order SHALL be preserved.
REQ-024 Input transfer = valid_i && ready_o; output transfer = valid_o && ready_i.
REQ-025 ready_o SHALL equal !SKID.valid && !halted_o && !rst_i; no combinational path from ready_i or valid_i.
REQ-026 Occupancy transitions: 0+in->1; 1+in+out->1 (new entry); 1+in->2 (entry into SKID); 1+out->0; 2+out->1 (SKID moves to MAIN); otherwise hold.
REQ-027 Latency: entry accepted at edge N into empty stage SHALL appear on valid_o/data_o/ctrl_o after edge N.
REQ-028 valid_o=0 SHALL force data_o=0 and ctrl_o=BUBBLE_CTRL (all zero except nop=1).
REQ-029 Accepting an entry with ctrl.end=1 SHALL set halted_o at that edge; the entry itself is stored and delivered normally.
REQ-030 flush_i at edge N SHALL clear both entries and halted_o; any input transfer that cycle is discarded; an output transfer that cycle counts as delivered.
REQ-031 stall_cnt_o SHALL increment each cycle valid_o && !ready_i, saturating at 2^CNT_W-1; stall_cnt_clr_i has priority over increment; flush_i does not clear it.

Reset
REQ-032 rst_i assertion SHALL immediately clear both entries, occ_o=0, valid_o=0, halted_o=0, stall_cnt_o=0, data_o=0, ctrl_o=BUBBLE_CTRL, ready_o=0.
REQ-033 ready_o SHALL be 1 in the first cycle after rst_i deasserts; reset mid-transfer SHALL discard all held entries.

Structure
REQ-034 Shared package SHALL hold stage_ctrl_t (packed struct), BUBBLE_CTRL constant, and parameter defaults.
REQ-035 Saturating counter SHALL be a sub-module named sat_counter (CNT_W, inc, clr).

Verification
REQ-036 Single entry data_i=64'h0102030405060708, ready_i=1 -> valid_o for exactly one cycle after the accepting edge, data_o matches, occ_o 1->0.
REQ-037 ready_i=0, push A then B -> occ_o=2, ready_o=0, C not accepted; ready_i=1 -> A then B delivered in order, occ_o 2->1->0.
REQ-038 ready_i=0 for 5 cycles with valid_o=1 -> stall_cnt_o=5; CNT_W=3, 10 stall cycles -> stall_cnt_o=7; stall_cnt_clr_i -> 0.
REQ-039 occ_o=2 with flush_i=1 and valid_i=1 -> next cycle occ_o=0, valid_o=0, ctrl_o.nop=1, input dropped.
REQ-040 Entry with ctrl.end=1 accepted -> halted_o=1, ready_o=0; entry delivered; flush_i -> halted_o=0, ready_o=1.
REQ-041 rst_i asserted between clock edges with occ_o=2 -> outputs cleared without a clock edge; ready_o=1 one cycle after deassert.
